// File: rtl/enigma_keyer.sv
// -----------------------------------------------------------------------------
// enigma_keyer
// Keyboard front end for an electro-mechanical style cipher stage. A raw
// pushbutton is synchronised and debounced; each accepted press drives one
// one-hot letter into the external rotor/reflector stage. The drive is held
// long enough for that stage to settle, then the returned lamp is sampled and
// encoded into a 5-bit cipher index.
//
// Optional feature macro: KEYER_AUTOREPEAT_EN
//   When defined, holding the key re-keys the current letter_in every
//   REPEAT_CYCLES cycles. When undefined, one character is produced per press.
//
// Ports
//   clock        in   1   sole clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   key_n        in   1   raw pushbutton, active-low, asynchronous
//   letter_in    in   5   plaintext letter index 0..25
//   rotor_in     out  26  one-hot drive to the rotor stage, zero when idle
//   lamp         in   26  one-hot return from the rotor stage
//   cipher_out   out  5   encoded index of the last good lamp capture
//   cipher_valid out  1   one-cycle pulse when cipher_out updates
//   busy         out  1   high whenever the FSM is not idle
//   err          out  1   one-cycle pulse on bad letter or bad lamp
// -----------------------------------------------------------------------------
module enigma_keyer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_n,
  input  logic [4:0]  letter_in,
  output logic [25:0] rotor_in,
  input  logic [25:0] lamp,
  output logic [4:0]  cipher_out,
  output logic        cipher_valid,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_DRIVE    = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;

  // One counter serves debounce, settle and release timing, so it must hold
  // the larger of the two limits.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  // DRIVE lasts SETTLE_CYCLES-1 cycles; the single CAPTURE cycle completes
  // the SETTLE_CYCLES-long rotor_in window.
  localparam logic [CNT_W-1:0] SET_LIM = CNT_W'(SETTLE_CYCLES - 1);

  // Reject configurations the timing scheme cannot honour.
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_CYCLES <= SETTLE_CYCLES) begin : g_bad_params
    $error("enigma_keyer: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_onehot26(input logic [25:0] v);
    return (v != 26'd0) && ((v & (v - 26'd1)) == 26'd0);
  endfunction

  function automatic logic [4:0] enc26(input logic [25:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [25:0] dec26(input logic [4:0] l);
    return 26'd1 << l;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic             key_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [25:0]      rotor_q, rotor_d;
  logic [4:0]       cipher_q, cipher_d;
  logic             cipher_valid_q, cipher_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Key is active-low: key_s == 0 means pressed.
  assign key_s = sync2_q;

`ifdef KEYER_AUTOREPEAT_EN
  localparam int               REP_W   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(REPEAT_CYCLES);

  logic [REP_W-1:0] rep_q, rep_d, rep_inc_s;
  logic             rep_hit_s;

  // Hold timer: runs from the first DRIVE cycle of a character while the key
  // stays low, so consecutive drives start exactly REPEAT_CYCLES apart.
  always_comb begin
    rep_inc_s = (rep_q == {REP_W{1'b1}}) ? rep_q : rep_q + REP_W'(1);
    rep_hit_s = 1'b0;
    rep_d     = {REP_W{1'b0}};
    if (key_s || (state_q == ST_IDLE) || (state_q == ST_DEBOUNCE)) begin
      rep_d = {REP_W{1'b0}};
    end else if ((state_q == ST_WAIT) && (rep_inc_s >= REP_LIM)) begin
      rep_hit_s = 1'b1;
      rep_d     = {REP_W{1'b0}};
    end else begin
      rep_d = rep_inc_s;
    end
  end

  // Hold timer register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rep_q <= {REP_W{1'b0}};
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  // Two-flop synchroniser for the asynchronous pushbutton; idles released.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and output logic of the keying FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rotor_d        = rotor_q;
    cipher_d       = cipher_q;
    cipher_valid_d = 1'b0;
    err_d          = 1'b0;
    cnt_inc_s      = cnt_sat_inc(cnt_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d   = {CNT_W{1'b0}};
        rotor_d = 26'd0;
        if (!key_s) begin
          state_d = ST_DEBOUNCE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DEBOUNCE: begin
        if (key_s) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_inc_s >= DEB_LIM) begin
          cnt_d = {CNT_W{1'b0}};
          if (letter_in > 5'd25) begin
            err_d   = 1'b1;
            state_d = ST_WAIT;
          end else begin
            // rotor_q doubles as the latched letter for the whole window.
            rotor_d = dec26(letter_in);
            state_d = ST_DRIVE;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      ST_DRIVE: begin
        if (cnt_inc_s >= SET_LIM) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      ST_CAPTURE: begin
        rotor_d = 26'd0;
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
        if (is_onehot26(lamp)) begin
          cipher_d       = enc26(lamp);
          cipher_valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (key_s) begin
          if (cnt_inc_s >= DEB_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          // Any low sample restarts the release qualification.
          cnt_d = {CNT_W{1'b0}};
`ifdef KEYER_AUTOREPEAT_EN
          if (rep_hit_s) begin
            if (letter_in > 5'd25) begin
              err_d = 1'b1;
            end else begin
              rotor_d = dec26(letter_in);
              state_d = ST_DRIVE;
            end
          end else begin
            state_d = ST_WAIT;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        rotor_d = 26'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM and registered output state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= {CNT_W{1'b0}};
      rotor_q        <= 26'd0;
      cipher_q       <= 5'd0;
      cipher_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rotor_q        <= rotor_d;
      cipher_q       <= cipher_d;
      cipher_valid_q <= cipher_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign rotor_in     = rotor_q;
  assign cipher_out   = cipher_q;
  assign cipher_valid = cipher_valid_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_enigma_keyer.sv
// Scoreboard bench for enigma_keyer. The stimulus side predicts, from the
// letter, press length and lamp wiring, which drives and which pulses a press
// must cause and queues them; a negedge monitor pops and compares.
module tb_enigma_keyer;
  localparam int DEB = 16;
  localparam int SET = 4;
  localparam int REP = 64;

  logic        clock;
  logic        resetn;
  logic        key_n;
  logic [4:0]  letter_in;
  logic [25:0] rotor_in;
  logic [25:0] lamp;
  logic [4:0]  cipher_out;
  logic        cipher_valid;
  logic        busy;
  logic        err;

  enigma_keyer #(
    .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES  (SET),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .key_n       (key_n),
    .letter_in   (letter_in),
    .rotor_in    (rotor_in),
    .lamp        (lamp),
    .cipher_out  (cipher_out),
    .cipher_valid(cipher_valid),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    bit         is_err;
    logic [4:0] val;
  } ev_t;

  ev_t         exp_q[$];
  logic [25:0] drv_q[$];
  int          pulse_times[$];
  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  int          lamp_mode  = 0;   // 0: rotation wiring, 1: 26'h3, 2: dead (zero)
  int          lamp_shift = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Rotor/reflector stand-in: a fixed rotation of the alphabet.
  always_comb begin
    lamp = 26'd0;
    if (lamp_mode == 1) begin
      lamp = 26'h3;
    end else if (lamp_mode == 0) begin
      for (int i = 0; i < 26; i++) begin
        if (rotor_in[i]) lamp[(i + lamp_shift) % 26] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  // Reference: what one keyed character must produce.
  task automatic predict(input int letter, input int mode, input int shift);
    ev_t e;
    if (letter > 25) begin
      e.is_err = 1'b1; e.val = 5'd0;
      exp_q.push_back(e);
    end else begin
      drv_q.push_back(26'd1 << letter);
      if (mode == 0) begin
        e.is_err = 1'b0; e.val = 5'((letter + shift) % 26);
      end else begin
        e.is_err = 1'b1; e.val = 5'd0;
      end
      exp_q.push_back(e);
    end
  endtask

  // Number of characters a press of 'len' low cycles must key.
  function automatic int chars_for(input int len);
    int n;
    if (len < DEB + 5) return 0;
    n = 1;
`ifdef KEYER_AUTOREPEAT_EN
    n = 1 + (len - DEB - 1) / REP;
`endif
    return n;
  endfunction

  task automatic press(input int letter, input int len, input int mode, input int shift, input bit chg);
    int n;
    lamp_mode  = mode;
    lamp_shift = shift;
    letter_in  = 5'(letter);
    n = chars_for(len);
    for (int k = 0; k < n; k++) predict(letter, mode, shift);
    key_n = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (chg && i == DEB + 5) letter_in = 5'($urandom_range(0, 31));
      tick(1);
    end
    key_n = 1'b1;
    tick(DEB + 12);
    check("busy_after_release", 32'(busy), 32'(0));
  endtask

  task automatic bounce(input int runs);
    for (int r = 0; r < runs; r++) begin
      key_n = 1'b0;
      tick($urandom_range(1, DEB - 2));
      key_n = 1'b1;
      tick($urandom_range(1, 2));
    end
    tick(DEB + 12);
    check("busy_after_bounce", 32'(busy), 32'(0));
  endtask

  // Monitor: pops the scoreboard on every pulse and tracks each drive window.
  initial begin
    ev_t         e;
    logic [25:0] run_val;
    int          run_len;
    logic [4:0]  last_cipher;
    run_len = 0;
    run_val = 26'd0;
    last_cipher = 5'd0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        run_len = 0;
        last_cipher = 5'd0;
      end else begin
        if (cipher_valid || err) begin
          if (cipher_valid) pulse_times.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_pulse: cipher_valid=%0b err=%0b, none expected", cipher_valid, err);
          end else begin
            e = exp_q.pop_front();
            check("pulse_is_err", 32'(err), 32'(e.is_err));
            check("pulse_exclusive", 32'(cipher_valid & err), 32'(0));
            if (e.is_err) begin
              check("cipher_held_on_err", 32'(cipher_out), 32'(last_cipher));
            end else begin
              check("cipher_value", 32'(cipher_out), 32'(e.val));
              last_cipher = e.val;
            end
          end
        end
        if (rotor_in != 26'd0) begin
          if (run_len == 0) begin
            if (drv_q.size() == 0) begin
              tests++; failed++;
              $display("FAIL unexpected_drive: rotor_in=%0h, none expected", rotor_in);
              run_val = rotor_in;
            end else begin
              run_val = drv_q.pop_front();
              check("rotor_value", 32'(rotor_in), 32'(run_val));
            end
          end else begin
            check("rotor_stable", 32'(rotor_in), 32'(run_val));
          end
          run_len++;
        end else if (run_len != 0) begin
          check("rotor_window_len", 32'(run_len), 32'(SET));
          run_len = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_exp;
    resetn = 1'b0;
    key_n = 1'b1;
    letter_in = 5'd0;
    tick(3);
    check("rst_rotor", 32'(rotor_in), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cipher", 32'(cipher_out), 32'(0));
    check("rst_valid", 32'(cipher_valid), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    resetn = 1'b1;
    tick(3);
    check("idle_busy", 32'(busy), 32'(0));

    // Loop-back shifted by 7: 'A' must come back as index 7.
    press(0, 40, 0, 7, 1'b0);
    check("loopback_cipher", 32'(cipher_out), 32'(7));

    // Short bounce produces nothing.
    key_n = 1'b0; tick(10); key_n = 1'b1; tick(DEB + 12);
    check("short_press_busy", 32'(busy), 32'(0));

    // Illegal letter.
    press(27, 40, 0, 3, 1'b0);
    // Two lamps lit, then a dead lamp: err, cipher_out kept.
    press(5, 40, 1, 0, 1'b0);
    check("lamp_multi_keep", 32'(cipher_out), 32'(7));
    press(6, 40, 2, 0, 1'b0);
    check("lamp_zero_keep", 32'(cipher_out), 32'(7));

    // Reset on the second DRIVE cycle.
    lamp_mode = 0; lamp_shift = 1; letter_in = 5'd9;
    drv_q.push_back(26'd1 << 9);
    key_n = 1'b0;
    w = 0;
    while (rotor_in == 26'd0 && w < 60) begin tick(1); w++; end
    check("reset_drive_seen", 32'(rotor_in != 26'd0), 32'(1));
    tick(1);
    #2 resetn = 1'b0;
    #1;
    check("reset_rotor_drop", 32'(rotor_in), 32'(0));
    check("reset_no_valid", 32'(cipher_valid), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_cipher", 32'(cipher_out), 32'(0));
    key_n = 1'b1;
    exp_q.delete();
    drv_q.delete();
    tick(3);
    resetn = 1'b1;
    tick(DEB + 10);
    press(25, 40, 0, 0, 1'b0);
    check("post_reset_cipher", 32'(cipher_out), 32'(25));

    // Randomised presses.
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 9))
        0, 1: bounce(1);
        2: bounce($urandom_range(2, 5));
        3: press($urandom_range(0, 25), $urandom_range(DEB + 5, DEB + 40), 1, 0, 1'b0);
        4: press($urandom_range(0, 25), $urandom_range(DEB + 5, DEB + 40), 2, 0, 1'b0);
        default: press($urandom_range(0, 31), $urandom_range(DEB + 5, DEB + 40), 0,
                       $urandom_range(0, 25), 1'($urandom_range(0, 1)));
      endcase
    end

    // Long hold: one character, or REP-spaced repeats with auto-repeat.
    tick(5);
    pulse_times.delete();
    n_exp = chars_for(300);
    press(4, 300, 0, 2, 1'b0);
    check("hold_pulse_count", 32'(pulse_times.size()), 32'(n_exp));
    for (int i = 1; i < pulse_times.size(); i++) begin
      check("hold_spacing", 32'(pulse_times[i] - pulse_times[i-1]), 32'(REP));
    end

    w = 0;
    while ((exp_q.size() != 0 || drv_q.size() != 0) && w < 200) begin tick(1); w++; end
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    check("drive_queue_empty", 32'(drv_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/enigma_keyer.md
ENIGMA_KEYER -- requirements
Module: enigma_keyer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronised low samples needed to accept a press.
REQ-002 Parameter SETTLE_CYCLES, default 4: cycles rotor_in is held before the lamp is sampled; legal range 2..255.
REQ-003 Parameter REPEAT_CYCLES, default 64: hold time before auto-repeat; used only with KEYER_AUTOREPEAT_EN.
REQ-004 Port: clock  input  1  sole clock, all state on rising edge.
REQ-005 Port: resetn  input  1  asynchronous, active-low reset.
REQ-006 Port: key_n  input  1  raw pushbutton, active-low, asynchronous to clock.
REQ-007 Port: letter_in  input  5  plaintext letter index, 0=A..25=Z.
REQ-008 Port: rotor_in  output  26  one-hot drive to the rotor/reflector stage; all-zero when idle.
REQ-009 Port: lamp  input  26  one-hot return from the rotor/reflector stage.
REQ-010 Port: cipher_out  output  5  encoded index of the last captured lamp.
REQ-011 Port: cipher_valid  output  1  one-cycle pulse, cipher_out updated.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: err  output  1  one-cycle pulse on rejected letter or non-one-hot lamp.

Function
REQ-014 key_n SHALL pass through a 2-flop synchroniser (reset to 1) before any use.
REQ-015 FSM states SHALL be IDLE, DEBOUNCE, DRIVE, CAPTURE, WAIT_RELEASE.
REQ-016 IDLE -> DEBOUNCE when synchronised key is low; counter cleared.
REQ-017 DEBOUNCE: counter increments each low sample; any high sample returns to IDLE; reaching DEBOUNCE_CYCLES SHALL check letter_in.
REQ-018 letter_in > 25 at acceptance SHALL pulse err, leave rotor_in zero, go to WAIT_RELEASE.
REQ-019 Valid letter SHALL be latched and state -> DRIVE; rotor_in = 1<<letter from the first DRIVE cycle.
REQ-020 rotor_in SHALL be stable for exactly SETTLE_CYCLES cycles (DRIVE plus CAPTURE); letter_in changes meanwhile are ignored.
REQ-021 On the edge ending CAPTURE: lamp encoded into cipher_out, cipher_valid pulses the following cycle, rotor_in returns to zero, state -> WAIT_RELEASE.
REQ-022 lamp zero or with more than one bit set at capture SHALL pulse err instead of cipher_valid; cipher_out retains its previous value.
REQ-023 WAIT_RELEASE -> IDLE only after DEBOUNCE_CYCLES consecutive high samples; a low sample restarts that count.
REQ-024 Exactly one rotor_in assertion per accepted press; a press shorter than DEBOUNCE_CYCLES SHALL produce no output.
REQ-025 Counters SHALL saturate, never wrap.

Reset
REQ-026 resetn low SHALL immediately force: state IDLE, rotor_in 0, cipher_out 0, cipher_valid 0, err 0, busy 0, counters 0, synchroniser 1.
REQ-027 Reset mid-DRIVE/CAPTURE SHALL drop rotor_in the same instant with no cipher_valid; first press after release is treated as new.

Configuration
REQ-028 Macro KEYER_AUTOREPEAT_EN defined: key held low in WAIT_RELEASE for REPEAT_CYCLES SHALL re-enter DRIVE with current letter_in (checked per REQ-018), repeating every REPEAT_CYCLES while held.
REQ-029 Macro undefined: no repeat logic; one character per press regardless of hold time.

Verification
REQ-030 key_n low 40 cycles, letter_in=0, lamp loops back rotor_in shifted to bit 7 -> rotor_in=26'h1 for 4 cycles, then cipher_valid once with cipher_out=7.
REQ-031 key_n low 10 cycles (bounce) then high -> rotor_in stays 0, busy returns 0, no pulses.
REQ-032 letter_in=27, key held 40 cycles -> err one pulse, rotor_in never nonzero.
REQ-033 lamp=26'h3 during capture -> err pulse, no cipher_valid, cipher_out unchanged.
REQ-034 resetn low on 2nd DRIVE cycle -> rotor_in=0 immediately, no cipher_valid; next clean press (letter 25) drives 26'h2000000.
REQ-035 With KEYER_AUTOREPEAT_EN, key held 300 cycles, letter 4 -> multiple cipher_valid pulses spaced REPEAT_CYCLES apart; without macro exactly one.
